// File: rtl/key_code_encoder_pkg.sv
// key_code_encoder_pkg
//   Shared constants and types for the pushbutton code encoder.
//   - Key index constants (which KEY bit performs which edit).
//   - Width of the held code.
//   - pick_winner(): resolves coincident press events by fixed priority
//     CLR > INC > DEC > LOAD.
package key_code_encoder_pkg;

  localparam int CODE_WIDTH = 3;
  localparam int NUM_KEYS   = 4;

  typedef logic [1:0] key_idx_t;

  localparam key_idx_t KEY_INC  = 2'd0;
  localparam key_idx_t KEY_DEC  = 2'd1;
  localparam key_idx_t KEY_CLR  = 2'd2;
  localparam key_idx_t KEY_LOAD = 2'd3;

  typedef struct packed {
    logic     valid;
    key_idx_t idx;
  } winner_t;

  // Highest-priority pending event; lower-priority ones are simply dropped.
  function automatic winner_t pick_winner(input logic [NUM_KEYS-1:0] evt);
    winner_t w;
    w.valid = |evt;
    if (evt[KEY_CLR]) begin
      w.idx = KEY_CLR;
    end else if (evt[KEY_INC]) begin
      w.idx = KEY_INC;
    end else if (evt[KEY_DEC]) begin
      w.idx = KEY_DEC;
    end else if (evt[KEY_LOAD]) begin
      w.idx = KEY_LOAD;
    end else begin
      w.idx = KEY_INC;
    end
    return w;
  endfunction

endpackage

// File: rtl/key_code_encoder_debounce.sv
// key_debounce
//   Two-flop synchroniser plus counter-based debouncer for one active-low
//   pushbutton. The stable level only follows the synchronised sample after
//   DEBOUNCE_CYCLES consecutive differing samples; any matching sample
//   restarts the count.
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   key_n_i        raw pushbutton, active-low, asynchronous to clk_i
//   stable_o       debounced level (1 = released, 0 = pressed)
//   pressed_evt_o  one-cycle pulse after the stable level goes released->pressed
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic stable_o,
  output logic pressed_evt_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             evt_q, evt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Debounce next-state: count disagreements, adopt the sample on the last one.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    evt_d    = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      // Only the released->pressed transition is an event.
      evt_d    = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchroniser, counter, stable level and event registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      evt_q    <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      evt_q    <= evt_d;
    end
  end

  assign stable_o      = stable_q;
  assign pressed_evt_o = evt_q;

endmodule

// File: rtl/key_code_encoder.sv
// key_code_encoder
//   Debounces the four board pushbuttons and turns each debounced press into
//   an edit of a held code that feeds the 7-segment decoder:
//   KEY[0] increment, KEY[1] decrement, KEY[2] clear, KEY[3] load from SW.
// Ports:
//   CLOCK_50  system clock (rising edge)
//   RESET     asynchronous active-high reset
//   KEY[3:0]  raw pushbuttons, active-low, asynchronous
//   SW[2:0]   load value, sampled on a KEY[3] event
//   code      held code
//   press     one-cycle strobe when code was updated by a key action
//   key_id    index of the key behind the last press, held until the next
module key_code_encoder
  import key_code_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CODE_W          = CODE_WIDTH
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [3:0]        KEY,
  input  logic [2:0]        SW,
  output logic [CODE_W-1:0] code,
  output logic              press,
  output logic [1:0]        key_id
);

  localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);

  logic [NUM_KEYS-1:0] evt_s;
  // Debounced levels are not used here; kept for other consumers.
  logic [NUM_KEYS-1:0] key_level_unused_s;
  winner_t             win_s;
  logic                accept_s;

  logic [CODE_W-1:0] code_q, code_d;
  logic              press_q, press_d;
  key_idx_t          key_id_q, key_id_d;

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk_i        (CLOCK_50),
        .rst_i        (RESET),
        .key_n_i      (KEY[g]),
        .stable_o     (key_level_unused_s[g]),
        .pressed_evt_o(evt_s[g])
      );
    end
  endgenerate

  // Priority select and code edit for the winning event.
  always_comb begin
    win_s    = pick_winner(evt_s);
    // An event arriving right after a strobe is dropped so press never
    // stays high for two consecutive cycles (only possible across keys).
    accept_s = win_s.valid & ~press_q;
    code_d   = code_q;
    key_id_d = key_id_q;
    press_d  = 1'b0;
    if (accept_s) begin
      press_d  = 1'b1;
      key_id_d = win_s.idx;
      case (win_s.idx)
        KEY_CLR:  code_d = '0;
        KEY_INC:  code_d = code_q + CODE_ONE;
        KEY_DEC:  code_d = code_q - CODE_ONE;
        KEY_LOAD: code_d = CODE_W'(SW);
        default:  code_d = code_q;
      endcase
    end else begin
      code_d = code_q;
    end
  end

  // Output registers.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      code_q   <= '0;
      press_q  <= 1'b0;
      key_id_q <= KEY_INC;
    end else begin
      code_q   <= code_d;
      press_q  <= press_d;
      key_id_q <= key_id_d;
    end
  end

  assign code   = code_q;
  assign press  = press_q;
  assign key_id = key_id_q;

endmodule

// File: tb/tb_key_code_encoder.sv
// Directed bench for key_code_encoder with DEBOUNCE_CYCLES = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
// Latency is measured in rising edges from the drive point: the first one is
// the first sampling edge, so an update DEBOUNCE_CYCLES+2 cycles later is
// seen at edge number DEBOUNCE_CYCLES+3 = 7.
module tb_key_code_encoder;

  localparam int DB      = 4;
  localparam int EXP_LAT = DB + 3;

  logic       CLOCK_50;
  logic       RESET;
  logic [3:0] KEY;
  logic [2:0] SW;
  logic [2:0] code;
  logic       press;
  logic [1:0] key_id;

  int n_checks = 0;
  int n_pass   = 0;
  int press_cnt = 0;

  key_code_encoder #(.DEBOUNCE_CYCLES(DB), .CODE_W(3)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET   (RESET),
    .KEY     (KEY),
    .SW      (SW),
    .code    (code),
    .press   (press),
    .key_id  (key_id)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Count strobes seen on each falling edge.
  always @(negedge CLOCK_50) begin
    if (press) press_cnt <= press_cnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Wait (bounded) for the next press strobe; returns edges waited or -1.
  task automatic wait_press(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge CLOCK_50);
      if (press) begin
        cyc = k;
        break;
      end
    end
  endtask

  // Press the given key mask, check latency/result, hold, release, check count.
  task automatic key_action(input logic [3:0] mask, input int exp_code,
                            input int exp_id, input string tag);
    int c0;
    int cyc;
    c0 = press_cnt;
    KEY = KEY & ~mask;
    wait_press(cyc);
    check({tag, "_latency"}, cyc, EXP_LAT);
    check({tag, "_code"}, int'(code), exp_code);
    check({tag, "_key_id"}, int'(key_id), exp_id);
    @(negedge CLOCK_50);
    check({tag, "_pulse_width"}, int'(press), 0);
    repeat (8) @(negedge CLOCK_50);
    KEY = KEY | mask;
    repeat (10) @(negedge CLOCK_50);
    check({tag, "_event_count"}, press_cnt - c0, 1);
  endtask

  logic bounce_pat [0:4];

  initial begin
    int c0;
    int cyc;
    bounce_pat[0] = 1'b0; bounce_pat[1] = 1'b1; bounce_pat[2] = 1'b0;
    bounce_pat[3] = 1'b0; bounce_pat[4] = 1'b1;

    RESET = 1'b1;
    KEY   = 4'b1111;
    SW    = 3'b000;
    repeat (3) @(negedge CLOCK_50);
    check("reset_code", int'(code), 0);
    check("reset_press", int'(press), 0);
    check("reset_key_id", int'(key_id), 0);
    RESET = 1'b0;
    repeat (3) @(negedge CLOCK_50);

    // Single increment held for 20 cycles: one event only.
    c0 = press_cnt;
    KEY = 4'b1110;
    wait_press(cyc);
    check("inc_latency", cyc, EXP_LAT);
    check("inc_code", int'(code), 1);
    check("inc_key_id", int'(key_id), 0);
    @(negedge CLOCK_50);
    check("inc_pulse_width", int'(press), 0);
    repeat (20) @(negedge CLOCK_50);
    check("inc_hold_events", press_cnt - c0, 1);
    KEY = 4'b1111;
    repeat (10) @(negedge CLOCK_50);
    check("inc_release_events", press_cnt - c0, 1);

    // Bounce on KEY[0]: 0,1,0,0,1 then a run of zeros held.
    c0 = press_cnt;
    for (int i = 0; i < 5; i++) begin
      KEY[0] = bounce_pat[i];
      @(negedge CLOCK_50);
    end
    check("bounce_no_early_event", press_cnt - c0, 0);
    KEY[0] = 1'b0;
    wait_press(cyc);
    check("bounce_latency", cyc, EXP_LAT);
    check("bounce_code", int'(code), 2);
    repeat (10) @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("bounce_events", press_cnt - c0, 1);

    // Clear, then decrement wraps 0 -> 7.
    key_action(4'b0100, 0, 2, "clr");
    key_action(4'b0010, 7, 1, "dec_wrap");

    // Eight increments from 7 walk 0..7.
    for (int i = 0; i < 8; i++) begin
      key_action(4'b0001, i, 0, $sformatf("inc_step%0d", i));
    end

    // Load from switches.
    SW = 3'b101;
    key_action(4'b1000, 5, 3, "load");
    SW = 3'b010;

    // KEY[2] and KEY[0] together: clear wins, single pulse.
    key_action(4'b0101, 0, 2, "simul_clr_inc");

    // KEY[0] held through a reset pulse.
    c0 = press_cnt;
    KEY[0] = 1'b0;
    wait_press(cyc);
    check("rst_hold_pre_code", int'(code), 1);
    repeat (3) @(negedge CLOCK_50);
    RESET = 1'b1;
    @(negedge CLOCK_50);
    check("rst_hold_code", int'(code), 0);
    check("rst_hold_press", int'(press), 0);
    check("rst_hold_key_id", int'(key_id), 0);
    repeat (2) @(negedge CLOCK_50);
    check("rst_hold_code_late", int'(code), 0);
    RESET = 1'b0;
    wait_press(cyc);
    check("rst_hold_latency", cyc, EXP_LAT);
    check("rst_hold_post_code", int'(code), 1);
    check("rst_hold_post_key_id", int'(key_id), 0);
    repeat (15) @(negedge CLOCK_50);
    check("rst_hold_events", press_cnt - c0, 2);
    KEY[0] = 1'b1;
    repeat (10) @(negedge CLOCK_50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
